// File: rtl/mem_ctrl_pkg.sv
// Shared types for the unified memory controller: access FSM state encoding
// and a helper that identifies the cycles in which a memory request is outstanding.
package mem_ctrl_pkg;

  localparam int MEM_STATE_W = 3;

  typedef enum logic [MEM_STATE_W-1:0] {
    MEM_ST_IDLE  = 3'd0,
    MEM_ST_FETCH = 3'd1,
    MEM_ST_LOAD  = 3'd2,
    MEM_ST_STORE = 3'd3,
    MEM_ST_DONE  = 3'd4
  } mem_state_t;

  function automatic logic is_access(input mem_state_t s);
    return (s == MEM_ST_FETCH) || (s == MEM_ST_LOAD) || (s == MEM_ST_STORE);
  endfunction

endpackage

// File: rtl/mem_timer.sv
// Saturating 8-bit wait counter; expired flags the last cycle the memory
// request may remain pending before the access is abandoned.
module mem_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_ctrl.sv
// Single-port memory controller for the multi-cycle CPU: serialises fetch,
// load and store onto a req/ack port, owns IR and MDR, and stalls the core.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic              load_req,
  input  logic              store_req,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] mdr,
  output logic              stall,
  output logic              misaligned,
  output logic              timeout,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  mem_state_t        state, state_d, sel_state;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic              in_access, any_req, timer_expired;
  logic              launch, mis_d, tmo_d, ir_we, mdr_we;

  assign in_access = is_access(state);
  assign any_req   = fetch_req | load_req | store_req;
  assign stall     = ((state == MEM_ST_IDLE) && any_req) || in_access;

  mem_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_access),
    .enable (in_access),
    .expired(timer_expired)
  );

  // Simultaneous requests are resolved fetch > load > store; losers are dropped.
  always_comb begin
    sel_addr  = addr;
    sel_state = MEM_ST_STORE;
    sel_we    = 1'b0;
    if (fetch_req) begin
      sel_addr  = pc;
      sel_state = MEM_ST_FETCH;
    end else if (load_req) begin
      sel_state = MEM_ST_LOAD;
    end else begin
      sel_we = 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    launch  = 1'b0;
    mis_d   = 1'b0;
    tmo_d   = 1'b0;
    ir_we   = 1'b0;
    mdr_we  = 1'b0;
    case (state)
      MEM_ST_IDLE: begin
        if (any_req) begin
          if (sel_addr[1:0] != 2'b00) begin
            state_d = MEM_ST_DONE;
            mis_d   = 1'b1;
          end else begin
            state_d = sel_state;
            launch  = 1'b1;
          end
        end
      end
      // An ack arriving in the same cycle the timer expires still completes the access.
      MEM_ST_FETCH, MEM_ST_LOAD, MEM_ST_STORE: begin
        if (mem_ack) begin
          state_d = MEM_ST_DONE;
          ir_we   = (state == MEM_ST_FETCH);
          mdr_we  = (state == MEM_ST_LOAD);
        end else if (timer_expired) begin
          state_d = MEM_ST_DONE;
          tmo_d   = 1'b1;
        end
      end
      MEM_ST_DONE: state_d = MEM_ST_IDLE;
      default:     state_d = MEM_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MEM_ST_IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      misaligned <= 1'b0;
      timeout    <= 1'b0;
      instr      <= '0;
      mdr        <= '0;
    end else begin
      mem_req    <= is_access(state_d);
      misaligned <= mis_d;
      timeout    <= tmo_d;
      if (launch) begin
        mem_addr  <= {sel_addr[ADDR_W-1:2], 2'b00};
        mem_wdata <= wdata;
        mem_we    <= sel_we;
      end
      if (ir_we)  instr <= mem_rdata;
      if (mdr_we) mdr   <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a per-cycle timeline model of each access
// compared against the DUT every cycle, plus literal pins on key results.
module tb_mem_ctrl;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst, fetch_req, load_req, store_req, mem_ack;
  logic [31:0] pc, addr, wdata, mem_rdata;
  logic [31:0] instr, mdr, mem_addr, mem_wdata;
  logic        stall, misaligned, timeout, mem_req, mem_we;

  int checks = 0;
  int passes = 0;

  logic        model_on = 1'b0;
  logic        exp_stall, exp_req, exp_we, exp_mis, exp_tmo;
  logic [31:0] exp_addr, exp_wdata, exp_instr, exp_mdr;

  int req_n, stall_n;

  mem_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .load_req(load_req), .store_req(store_req),
    .pc(pc), .addr(addr), .wdata(wdata),
    .instr(instr), .mdr(mdr), .stall(stall),
    .misaligned(misaligned), .timeout(timeout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic resetModel();
    exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_mis = 1'b0; exp_tmo = 1'b0;
    exp_addr = '0; exp_wdata = '0; exp_instr = '0; exp_mdr = '0;
  endtask

  // Mid-cycle comparison of every observable output against the model.
  always @(negedge clk) begin
    if (model_on) begin
      checkOutput("stall", {31'd0, stall}, {31'd0, exp_stall});
      checkOutput("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
      checkOutput("misaligned", {31'd0, misaligned}, {31'd0, exp_mis});
      checkOutput("timeout", {31'd0, timeout}, {31'd0, exp_tmo});
      checkOutput("instr", instr, exp_instr);
      checkOutput("mdr", mdr, exp_mdr);
      if (exp_req) begin
        checkOutput("mem_addr", mem_addr, exp_addr);
        checkOutput("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
        if (exp_we) checkOutput("mem_wdata", mem_wdata, exp_wdata);
      end
    end
  end

  // One request held by the frozen control FSM until the DONE cycle, then one idle cycle.
  // k = request cycle carrying the ack (0 = never); rst_at = cycle index to pulse reset (-1 = none).
  task automatic applyStimulus(input logic f, input logic l, input logic s,
                               input logic [31:0] p, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rd,
                               input int k, input int rst_at,
                               output int req_cycles, output int stall_cycles);
    logic [31:0] tgt;
    logic        is_fetch, is_load, is_store, mis, acked;
    int          len, last;
    tgt      = f ? p : a;
    is_fetch = f;
    is_load  = !f && l;
    is_store = !f && !l && s;
    mis      = (tgt[1:0] != 2'b00);
    acked    = !mis && (k >= 1) && (k <= TMO);
    len      = mis ? 0 : (acked ? k : TMO);
    last     = len + 1;
    req_cycles   = 0;
    stall_cycles = 0;
    for (int c = 0; c <= last + 1; c++) begin
      @(posedge clk);
      #1;
      fetch_req = (c <= last) ? f : 1'b0;
      load_req  = (c <= last) ? l : 1'b0;
      store_req = (c <= last) ? s : 1'b0;
      pc = p; addr = a; wdata = wd;
      mem_ack   = (c == 0) || (acked && c == k) || (c >= last);
      mem_rdata = (acked && c == k) ? rd : (rd ^ 32'hA5A5_0000 ^ 32'(c));
      exp_stall = (c == 0) || (c >= 1 && c <= len);
      exp_req   = (c >= 1) && (c <= len);
      exp_we    = is_store;
      exp_addr  = {tgt[31:2], 2'b00};
      exp_wdata = wd;
      exp_mis   = mis && (c == 1);
      exp_tmo   = !mis && !acked && (c == last);
      if (acked && c == last) begin
        if (is_fetch) exp_instr = rd;
        if (is_load)  exp_mdr   = rd;
      end
      if (c == rst_at) begin
        #1;
        rst = 1'b1;
        fetch_req = 1'b0; load_req = 1'b0; store_req = 1'b0; mem_ack = 1'b0;
        resetModel();
        #1;
        checkOutput("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("rst_mid_stall", {31'd0, stall}, 32'd0);
        checkOutput("rst_mid_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mid_instr", instr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        break;
      end
      #2;
      if (mem_req) req_cycles++;
      if (stall)   stall_cycles++;
    end
  endtask

  initial begin
    rst = 1'b1;
    fetch_req = 1'b0; load_req = 1'b0; store_req = 1'b0; mem_ack = 1'b0;
    pc = '0; addr = '0; wdata = '0; mem_rdata = '0;
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_instr", instr, 32'd0);
    checkOutput("reset_mdr", mdr, 32'd0);
    checkOutput("reset_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("reset_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'd0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
    checkOutput("reset_flags", {29'd0, stall, misaligned, timeout}, 32'd0);
    model_on = 1'b1;
    rst = 1'b0;

    // Fetch, ack on first request cycle.
    applyStimulus(1, 0, 0, 32'h0000_0040, 32'h0, 32'h0, 32'h2008_0005, 1, -1, req_n, stall_n);
    checkOutput("lit_fetch_instr", instr, 32'h2008_0005);
    checkOutput("lit_fetch_stall_cycles", 32'(stall_n), 32'd2);
    checkOutput("lit_fetch_req_cycles", 32'(req_n), 32'd1);

    // Load so MDR holds a known value.
    applyStimulus(0, 1, 0, 32'h0, 32'h0000_0200, 32'h0, 32'h1234_5678, 2, -1, req_n, stall_n);
    checkOutput("lit_load_mdr", mdr, 32'h1234_5678);

    // Store, ack after 4 cycles; IR and MDR untouched.
    applyStimulus(0, 0, 1, 32'h0, 32'h0000_0100, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 4, -1, req_n, stall_n);
    checkOutput("lit_store_req_cycles", 32'(req_n), 32'd4);
    checkOutput("lit_store_instr", instr, 32'h2008_0005);
    checkOutput("lit_store_mdr", mdr, 32'h1234_5678);

    // Misaligned load and store: no memory access at all.
    applyStimulus(0, 1, 0, 32'h0, 32'h0000_0102, 32'h0, 32'h5555_5555, 1, -1, req_n, stall_n);
    checkOutput("lit_mis_req_cycles", 32'(req_n), 32'd0);
    checkOutput("lit_mis_stall_cycles", 32'(stall_n), 32'd1);
    checkOutput("lit_mis_mdr", mdr, 32'h1234_5678);
    applyStimulus(0, 0, 1, 32'h0, 32'h0000_0103, 32'h0BAD_F00D, 32'h0, 1, -1, req_n, stall_n);

    // Load with no ack times out; the next fetch completes normally.
    applyStimulus(0, 1, 0, 32'h0, 32'h0000_0300, 32'h0, 32'h7777_7777, 0, -1, req_n, stall_n);
    checkOutput("lit_tmo_req_cycles", 32'(req_n), 32'd8);
    checkOutput("lit_tmo_mdr", mdr, 32'h1234_5678);
    applyStimulus(1, 0, 0, 32'h0000_0044, 32'h0, 32'h0, 32'hCAFE_0001, 3, -1, req_n, stall_n);
    checkOutput("lit_after_tmo_instr", instr, 32'hCAFE_0001);

    // Ack in the same cycle the timer expires: ack wins.
    applyStimulus(0, 1, 0, 32'h0, 32'h0000_0308, 32'h0, 32'h0F0F_1234, TMO, -1, req_n, stall_n);
    checkOutput("lit_ack_at_expiry_mdr", mdr, 32'h0F0F_1234);

    // Simultaneous requests: fetch beats load, load beats store.
    applyStimulus(1, 1, 0, 32'h0000_0080, 32'h0000_0400, 32'h0, 32'h8888_0080, 1, -1, req_n, stall_n);
    checkOutput("lit_prio_instr", instr, 32'h8888_0080);
    checkOutput("lit_prio_mdr", mdr, 32'h0F0F_1234);
    applyStimulus(0, 1, 1, 32'h0, 32'h0000_0404, 32'h1111_2222, 32'h4444_0404, 2, -1, req_n, stall_n);
    checkOutput("lit_prio2_mdr", mdr, 32'h4444_0404);

    // Reset in the middle of a load, then a fresh fetch.
    applyStimulus(0, 1, 0, 32'h0, 32'h0000_0500, 32'h0, 32'h0, 0, 3, req_n, stall_n);
    applyStimulus(1, 0, 0, 32'h0000_0048, 32'h0, 32'h0, 32'h0123_4567, 2, -1, req_n, stall_n);
    checkOutput("lit_post_rst_instr", instr, 32'h0123_4567);
    checkOutput("lit_post_rst_mdr", mdr, 32'h0);

    @(posedge clk);
    #1;
    model_on = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
